// File: rtl/adc_meter_pkg.sv
// Shared types and widths for the multi-channel ADC scan meter.
package adc_meter_pkg;

    localparam int MV_W   = 13;
    localparam int BCD_W  = 16;
    localparam int PROD_W = 26;
    localparam int MAX_CH = 8;

    typedef enum logic {
        SCAN_ISSUE,
        SCAN_WAIT
    } scan_state_t;

    typedef enum logic [1:0] {
        CONV_IDLE,
        CONV_DIV,
        CONV_BCD,
        CONV_DONE
    } conv_state_t;

    typedef logic [3:0] bcd_digit_t;

    // Double-dabble correction: every BCD digit of 5 or more gets +3 before the shift.
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        bcd_digit_t       d;
        r = v;
        for (int i = 0; i < BCD_W / 4; i++) begin
            d = v[i*4 +: 4];
            if (d >= 4'd5) d = d + 4'd3;
            r[i*4 +: 4] = d;
        end
        return r;
    endfunction

endpackage

// File: rtl/mv_bcd_converter.sv
// Sequential average-to-millivolt scaler and BCD encoder.
//
// state     | meaning
// CONV_IDLE | waiting for start, product latched on start
// CONV_DIV  | restoring divide by full-scale code, one quotient bit per cycle
// CONV_BCD  | double-dabble of the saturated 13-bit quotient
// CONV_DONE | publish mv/bcd and pulse done
module mv_bcd_converter
    import adc_meter_pkg::*;
#(
    parameter int DATA_W  = 12,
    parameter int GAIN    = 2,
    parameter int VREF_MV = 2500
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [DATA_W-1:0] avg,
    output logic              busy,
    output logic              done,
    output logic [MV_W-1:0]   mv,
    output logic [BCD_W-1:0]  bcd
);

    localparam logic [PROD_W-1:0] SCALE   = PROD_W'(GAIN * VREF_MV);
    localparam logic [DATA_W:0]   DIVISOR = {1'b0, {DATA_W{1'b1}}};
    localparam logic [MV_W-1:0]   MV_MAX  = '1;
    localparam logic [BCD_W-1:0]  BCD_MAX = 16'h9999;

    conv_state_t        state;
    logic [4:0]         iter;
    logic [PROD_W-1:0]  dq;
    logic [DATA_W-1:0]  rem;
    logic [MV_W-1:0]    quo;
    logic [MV_W-1:0]    bin;
    logic [BCD_W-1:0]   bcd_acc;

    logic [PROD_W-1:0]  product;
    logic [DATA_W:0]    rem_shift;
    logic               rem_ge;
    logic [PROD_W-1:0]  q_next;
    logic [MV_W-1:0]    quo_sat;
    logic [BCD_W-1:0]   bcd_adj;

    assign product   = PROD_W'(avg) * SCALE;
    assign rem_shift = {rem, dq[PROD_W-1]};
    assign rem_ge    = rem_shift >= DIVISOR;
    assign q_next    = {dq[PROD_W-2:0], rem_ge};
    assign quo_sat   = (|q_next[PROD_W-1:MV_W]) ? MV_MAX : q_next[MV_W-1:0];
    assign bcd_adj   = dabble_adjust(bcd_acc);
    assign busy      = (state != CONV_IDLE);

    // Divide then double-dabble; dq holds the dividend and collects quotient bits.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= CONV_IDLE;
            iter    <= '0;
            dq      <= '0;
            rem     <= '0;
            quo     <= '0;
            bin     <= '0;
            bcd_acc <= '0;
            done    <= 1'b0;
            mv      <= '0;
            bcd     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                CONV_IDLE: begin
                    if (start) begin
                        dq    <= product;
                        rem   <= '0;
                        iter  <= 5'(PROD_W - 1);
                        state <= CONV_DIV;
                    end
                end
                CONV_DIV: begin
                    rem <= rem_ge ? DATA_W'(rem_shift - DIVISOR) : rem_shift[DATA_W-1:0];
                    dq  <= q_next;
                    if (iter == '0) begin
                        quo     <= quo_sat;
                        bin     <= quo_sat;
                        bcd_acc <= '0;
                        iter    <= 5'(MV_W - 1);
                        state   <= CONV_BCD;
                    end else begin
                        iter <= iter - 5'd1;
                    end
                end
                CONV_BCD: begin
                    bcd_acc <= {bcd_adj[BCD_W-2:0], bin[MV_W-1]};
                    bin     <= bin << 1;
                    if (iter == '0) state <= CONV_DONE;
                    else            iter  <= iter - 5'd1;
                end
                default: begin
                    done  <= 1'b1;
                    mv    <= quo;
                    bcd   <= ({1'b0, quo} > 14'd9999) ? BCD_MAX : bcd_acc;
                    state <= CONV_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/adc_scan_meter.sv
// Round-robin modular-ADC scanner with per-channel box-car averaging and
// millivolt/BCD readout of the selected channel.
//
// state      | meaning
// SCAN_ISSUE | command offered on cmd_valid until accepted
// SCAN_WAIT  | waiting for the matching response or the timeout
module adc_scan_meter
    import adc_meter_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int FIRST_CH    = 1,
    parameter int DATA_W      = 12,
    parameter int AVG_LOG2    = 2,
    parameter int VREF_MV     = 2500,
    parameter int GAIN        = 2,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic              Clk,
    input  logic              Reset,
    output logic              cmd_valid,
    output logic [4:0]        cmd_channel,
    input  logic              cmd_ready,
    input  logic              rsp_valid,
    input  logic [4:0]        rsp_channel,
    input  logic [DATA_W-1:0] rsp_data,
    input  logic [2:0]        sel_ch,
    input  logic              hold,
    output logic [MV_W-1:0]   mv_out,
    output logic [BCD_W-1:0]  bcd_out,
    output logic              bcd_valid,
    output logic              timeout_err
);

    localparam int               ACC_W    = DATA_W + AVG_LOG2;
    localparam int               TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [2:0]       LAST_IDX = 3'(NUM_CH - 1);
    localparam logic [AVG_LOG2:0] AVG_N   = (AVG_LOG2 + 1)'(1 << AVG_LOG2);

    scan_state_t        state;
    logic [2:0]         idx;
    logic [TMO_W-1:0]   tmo;
    logic [ACC_W-1:0]   acc [MAX_CH];
    logic [AVG_LOG2:0]  cnt [MAX_CH];
    logic [DATA_W-1:0]  avg [MAX_CH];

    logic               accept;
    logic               avg_wr;
    logic [ACC_W-1:0]   sum;
    logic [AVG_LOG2:0]  cnt_next;
    logic [2:0]         next_idx;
    logic [2:0]         sel_idx;
    logic [2:0]         sel_q;
    logic               conv_req;
    logic               pending;
    logic               conv_start;
    logic               conv_busy;
    logic               conv_done;
    logic [MV_W-1:0]    conv_mv;
    logic [BCD_W-1:0]   conv_bcd;

    assign cmd_channel = 5'(FIRST_CH) + {2'b00, idx};
    assign accept      = (state == SCAN_WAIT) && rsp_valid && (rsp_channel == cmd_channel);
    assign sum         = acc[idx] + ACC_W'(rsp_data);
    assign cnt_next    = cnt[idx] + (AVG_LOG2 + 1)'(1);
    assign avg_wr      = accept && (cnt_next == AVG_N);
    assign next_idx    = (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
    assign sel_idx     = (sel_ch > LAST_IDX) ? LAST_IDX : sel_ch;
    assign conv_req    = (avg_wr && (idx == sel_idx)) || (sel_idx != sel_q);
    assign conv_start  = pending && !conv_busy;

    // Scan FSM: command handshake, response accumulation and timeout recovery.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= SCAN_ISSUE;
            idx         <= '0;
            cmd_valid   <= 1'b0;
            tmo         <= '0;
            timeout_err <= 1'b0;
            for (int i = 0; i < MAX_CH; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
                avg[i] <= '0;
            end
        end else begin
            case (state)
                SCAN_ISSUE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_valid <= 1'b0;
                        tmo       <= TMO_W'(TIMEOUT_CYC);
                        state     <= SCAN_WAIT;
                    end else begin
                        cmd_valid <= 1'b1;
                    end
                end
                default: begin
                    if (accept) begin
                        if (avg_wr) begin
                            avg[idx] <= DATA_W'(sum >> AVG_LOG2);
                            acc[idx] <= '0;
                            cnt[idx] <= '0;
                        end else begin
                            acc[idx] <= sum;
                            cnt[idx] <= cnt_next;
                        end
                        idx       <= next_idx;
                        cmd_valid <= 1'b1;
                        state     <= SCAN_ISSUE;
                    end else if (tmo == TMO_W'(1)) begin
                        timeout_err <= 1'b1;
                        idx         <= next_idx;
                        cmd_valid   <= 1'b1;
                        state       <= SCAN_ISSUE;
                    end else begin
                        tmo <= tmo - TMO_W'(1);
                    end
                end
            endcase
        end
    end

    // Conversion requests collapse into one pending flag; the next start reads the live average.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sel_q   <= '0;
            pending <= 1'b0;
        end else begin
            sel_q   <= sel_idx;
            pending <= conv_start ? conv_req : (pending || conv_req);
        end
    end

    mv_bcd_converter #(
        .DATA_W  (DATA_W),
        .GAIN    (GAIN),
        .VREF_MV (VREF_MV)
    ) u_conv (
        .Clk   (Clk),
        .Reset (Reset),
        .start (conv_start),
        .avg   (avg[sel_idx]),
        .busy  (conv_busy),
        .done  (conv_done),
        .mv    (conv_mv),
        .bcd   (conv_bcd)
    );

    // Display registers load on completion unless held.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            mv_out    <= '0;
            bcd_out   <= '0;
            bcd_valid <= 1'b0;
        end else begin
            bcd_valid <= conv_done && !hold;
            if (conv_done && !hold) begin
                mv_out  <= conv_mv;
                bcd_out <= conv_bcd;
            end
        end
    end

endmodule
